tri_bus_arbiter: RTL and testbench
==================================

// Module: tri_bus_arbiter
// PURPOSE
//  Round-robin arbiter for a shared tri-state bus. Sits directly upstream of
//  the per-master tri_state drivers: oe[i] drives the select input of master
//  i's tri_state buffer. Exactly one master owns the bus at a time. Every
//  ownership change inserts one dead (all-Z) turnaround cycle.
// PARAMETERS
//  N_MASTERS  4  number of requesting masters (>=2)
//  MAX_HOLD   8  max consecutive grant cycles per owner (>=1; used only when
//                ARB_TIMEOUT_EN is defined)
// PORTS
//  clk     in   1             rising-edge clock
//  rst_n   in   1             asynchronous, active-low reset
//  req     in   N_MASTERS     req[i]=1: master i wants or keeps the bus (level)
//  gnt     out  N_MASTERS     one-hot grant (registered)
//  oe      out  N_MASTERS     one-hot tri-state enable to drivers (registered)
//  owner   out  OW            index of current owner; OW=max(1,$clog2(N_MASTERS))
//  busy    out  1             1 while any gnt bit is high
// BEHAVIOUR
//  - Reset (async, rst_n=0): gnt=0, oe=0, owner=0, busy=0, state=IDLE,
//    hold_cnt=0, last=N_MASTERS-1. Outputs clear immediately, even mid-grant.
//  - States: IDLE, GRANT, TURN. All outputs are registered; no comb req->gnt path.
//  - IDLE: if |req at a clock edge, pick winner w. Then gnt=oe=onehot(w),
//    owner=w, busy=1, state=GRANT, hold_cnt=0. Req-to-grant latency is 1 cycle.
//    If req==0, stay in IDLE.
//  - Winner: first i with req[i]=1, searching (last+1)..(last+N_MASTERS) mod
//    N_MASTERS. The first grant after reset therefore favours master 0.
//  - GRANT: gnt and oe hold steady; hold_cnt increments every cycle.
//    Release condition: req[owner]==0, or (ARB_TIMEOUT_EN and
//    hold_cnt==MAX_HOLD-1). On release: gnt=oe=0, busy=0, last=owner,
//    state=TURN. owner keeps its old value.
//    Changes to other req bits during GRANT are ignored (no preemption).
//  - TURN: lasts exactly 1 cycle with oe=0 (bus fully Z). At its end,
//    arbitrate exactly as in IDLE: go to GRANT if |req, else to IDLE.
//  - A timed-out owner that still requests has lowest priority in the next
//    round. It is re-granted after TURN only if no other master requests.
//  - Invariants: $onehot0(gnt); oe==gnt; between two different nonzero oe
//    values there is >=1 cycle with oe==0.
//  - hold_cnt width: $clog2(MAX_HOLD+1). hold_cnt saturates rather than wraps
//    when ARB_TIMEOUT_EN is undefined.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: an owner loses the bus after exactly MAX_HOLD
//    grant cycles, even if its req stays high.
//  ARB_TIMEOUT_EN undefined: only the owner dropping req releases the bus.
//    MAX_HOLD is ignored and an owner may hold the bus indefinitely.
// TESTING
//  1 Reset: rst_n=0 asserted mid-GRANT (gnt=0010) -> gnt/oe/busy=0 at once;
//    after release with req=0 the block stays IDLE.
//  2 Single request: req=0100 at cycle 0 -> gnt=oe=0100, owner=2 from cycle 1.
//    req drops at cycle 4 -> oe=0 from cycle 5, state IDLE from cycle 6.
//  3 Round robin: req=1111 held, each master drops req after 2 grant cycles
//    -> grant order 0,1,2,3,0. Exactly one oe=0 cycle between owners.
//  4 Timeout (ARB_TIMEOUT_EN, MAX_HOLD=8): req=0011 held -> master 0 owns 8
//    cycles, 1 TURN cycle, master 1 owns 8 cycles, then master 0 again.
//  5 No timeout (macro undefined): req=0001 held 50 cycles while req[1]=1
//    -> gnt=0001 for all 50 cycles; gnt[1] never asserts.
//  6 Contention check: random req for 10k cycles -> $onehot0(oe) holds every
//    cycle, oe==gnt, and a dead cycle precedes every owner change.

Source files
------------

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus, with a one-cycle dead turnaround on every ownership change.
// Optional hold-time limit: define ARB_TIMEOUT_EN to release an owner after MAX_HOLD grant cycles.
`timescale 1ns/1ps
module tri_bus_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int MAX_HOLD  = 8,
  localparam int OW = (N_MASTERS > 2) ? $clog2(N_MASTERS) : 1,
  localparam int HW = $clog2(MAX_HOLD + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_MASTERS-1:0] req,
  output logic [N_MASTERS-1:0] gnt,
  output logic [N_MASTERS-1:0] oe,
  output logic [OW-1:0]        owner,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        last_q, last_d;
  logic [HW-1:0]        hold_q, hold_d;

  logic                 win_found;
  logic [OW-1:0]        win_idx;
  logic [OW-1:0]        cand;
  logic [N_MASTERS-1:0] win_onehot;
  logic                 hold_expired;
  logic                 release_bus;

  // Rotating priority: the search starts just after the previous owner.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    cand       = '0;
    win_onehot = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      cand = OW'((int'(last_q) + k) % N_MASTERS);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_onehot[win_idx] = win_found;
  end

`ifdef ARB_TIMEOUT_EN
  assign hold_expired = (hold_q == HW'(MAX_HOLD - 1));
`else
  assign hold_expired = 1'b0;
`endif

  assign release_bus = !req[owner_q] || hold_expired;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE, TURN: begin
        if (win_found) begin
          state_d = GRANT;
          gnt_d   = win_onehot;
          owner_d = win_idx;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_bus) begin
          state_d = TURN;
          gnt_d   = '0;
          last_d  = owner_q;
          hold_d  = '0;
        end else if (hold_q != HW'(MAX_HOLD)) begin
          // Saturate so an unlimited hold never wraps the counter.
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= OW'(N_MASTERS - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  // oe is the grant register itself, so oe==gnt by construction.
  assign gnt   = gnt_q;
  assign oe    = gnt_q;
  assign owner = owner_q;
  assign busy  = |gnt_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: vector tables with a scoreboard queue, async reset, round robin,
// hold behaviour (ARB_TIMEOUT_EN selects the timeout or the unlimited-hold sequence) and random invariants.
`timescale 1ns/1ps
module tb_tri_bus_arbiter;

  localparam int N  = 4;
  localparam int OW = 2;
  localparam int W  = N + N + OW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt;
  logic [N-1:0]  oe;
  logic [OW-1:0] owner;
  logic          busy;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [OW-1:0] owner;
    logic          busy;
  } vec_t;

  vec_t vecs[$];

  tri_bus_arbiter #(.N_MASTERS(N), .MAX_HOLD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .oe    (oe),
    .owner (owner),
    .busy  (busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // checking helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: actual=empty_queue required=entry", name);
    end else begin
      e = exp_q.pop_front();
      chk(name, 32'({gnt, oe, owner, busy}), 32'(e));
    end
  endtask

  function automatic vec_t mk(logic [N-1:0] r, logic [N-1:0] g, logic [OW-1:0] o, logic b);
    vec_t v;
    v.req = r;
    v.gnt = g;
    v.owner = o;
    v.busy = b;
    return v;
  endfunction

  // driver: each vector's req is sampled by the next rising edge, outputs checked on the falling edge
  task automatic run_vecs(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      req = vecs[i].req;
      exp_q.push_back({vecs[i].gnt, vecs[i].gnt, vecs[i].owner, vecs[i].busy});
      @(negedge clk);
      check_out($sformatf("%s[%0d]", name, i));
    end
    vecs.delete();
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk(name, 32'({gnt, oe, owner, busy}), 32'd0);
  endtask

  logic [N-1:0] prev_oe;
  logic [N-1:0] sampled_req;

  initial begin
    do_reset("reset_state");

    // async reset in the middle of a grant
    vecs.push_back(mk(4'b0010, 4'b0010, 2'd1, 1'b1));
    vecs.push_back(mk(4'b0010, 4'b0010, 2'd1, 1'b1));
    run_vecs("pre_reset_grant");
    #2 rst_n = 1'b0;
    #1 chk("async_reset_clears", 32'({gnt, oe, owner, busy}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req   = '0;
    for (int i = 0; i < 3; i++) vecs.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
    run_vecs("post_reset_idle");

    // single request, then drop: one TURN cycle, then idle
    for (int i = 0; i < 4; i++) vecs.push_back(mk(4'b0100, 4'b0100, 2'd2, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0000, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b0000, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b0000, 2'd2, 1'b0));
    run_vecs("single_req");

    // round robin 0,1,2,3,0 with every master dropping after two grant cycles
    do_reset("reset_rr");
    vecs.push_back(mk(4'b1111, 4'b0001, 2'd0, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b0001, 2'd0, 1'b1));
    vecs.push_back(mk(4'b1110, 4'b0000, 2'd0, 1'b0));
    vecs.push_back(mk(4'b1111, 4'b0010, 2'd1, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b0010, 2'd1, 1'b1));
    vecs.push_back(mk(4'b1101, 4'b0000, 2'd1, 1'b0));
    vecs.push_back(mk(4'b1111, 4'b0100, 2'd2, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b0100, 2'd2, 1'b1));
    vecs.push_back(mk(4'b1011, 4'b0000, 2'd2, 1'b0));
    vecs.push_back(mk(4'b1111, 4'b1000, 2'd3, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b1000, 2'd3, 1'b1));
    vecs.push_back(mk(4'b0111, 4'b0000, 2'd3, 1'b0));
    vecs.push_back(mk(4'b1111, 4'b0001, 2'd0, 1'b1));
    // sparse requests: rotation skips non-requesters and wraps
    vecs.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
    vecs.push_back(mk(4'b1010, 4'b0010, 2'd1, 1'b1));
    vecs.push_back(mk(4'b1000, 4'b0000, 2'd1, 1'b0));
    vecs.push_back(mk(4'b1001, 4'b1000, 2'd3, 1'b1));
    vecs.push_back(mk(4'b0001, 4'b0000, 2'd3, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b0000, 2'd3, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b0000, 2'd3, 1'b0));
    vecs.push_back(mk(4'b0001, 4'b0001, 2'd0, 1'b1));
    run_vecs("round_robin");

    do_reset("reset_hold");
`ifdef ARB_TIMEOUT_EN
    // timeout: 8 cycles each, one dead cycle between, timed-out owner goes last
    for (int i = 0; i < 8; i++) vecs.push_back(mk(4'b0011, 4'b0001, 2'd0, 1'b1));
    vecs.push_back(mk(4'b0011, 4'b0000, 2'd0, 1'b0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(4'b0011, 4'b0010, 2'd1, 1'b1));
    vecs.push_back(mk(4'b0011, 4'b0000, 2'd1, 1'b0));
    vecs.push_back(mk(4'b0011, 4'b0001, 2'd0, 1'b1));
    run_vecs("timeout");
`else
    // no timeout: master 0 keeps the bus while master 1 waits
    for (int i = 0; i < 50; i++) vecs.push_back(mk(4'b0011, 4'b0001, 2'd0, 1'b1));
    run_vecs("no_timeout");
`endif

    // random contention with invariant checks every cycle
    do_reset("reset_random");
    prev_oe = '0;
    for (int c = 0; c < 10000; c++) begin
      req = N'($urandom_range(0, 15));
      sampled_req = req;
      @(negedge clk);
      chk("rand_onehot0", 32'($onehot0(oe)), 32'd1);
      chk("rand_oe_eq_gnt", 32'(oe), 32'(gnt));
      chk("rand_busy", 32'(busy), 32'(|gnt));
      chk("rand_dead_cycle", 32'(!(prev_oe != 0 && oe != 0 && oe != prev_oe)), 32'd1);
      if (prev_oe == 0 && oe != 0)
        chk("rand_grant_to_requester", 32'((oe & sampled_req) != 0), 32'd1);
`ifndef ARB_TIMEOUT_EN
      if (prev_oe != 0 && oe == 0)
        chk("rand_release_on_drop", 32'(prev_oe & sampled_req), 32'd0);
`endif
      prev_oe = oe;
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
